// File: rtl/trigger_sequencer_pkg.sv
// Shared types for the multi-stage capture trigger: stage configuration record,
// sequencer state encoding and the per-channel edge qualification helper.
package trigger_sequencer_pkg;

    localparam int SAMPLE_WIDTH = 8;
    localparam int NUM_STAGES   = 4;
    localparam int COUNT_WIDTH  = 16;
    localparam int STAGE_WIDTH  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef logic [SAMPLE_WIDTH-1:0] sample_t;
    typedef logic [STAGE_WIDTH-1:0]  stage_idx_t;
    typedef logic [COUNT_WIDTH-1:0]  count_t;

    typedef struct packed {
        sample_t mask;
        sample_t value;
        sample_t rise;
        sample_t fall;
        count_t  count;
        logic    last;
    } stage_cfg_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        FIRED
    } trig_state_e;

    // Channels with both rise and fall requested accept either edge.
    function automatic logic edges_ok(sample_t need_rise, sample_t need_fall,
                                      sample_t rise, sample_t fall);
        sample_t miss;
        miss = (need_rise & ~need_fall & ~rise)
             | (need_fall & ~need_rise & ~fall)
             | (need_rise &  need_fall & ~(rise | fall));
        return miss == '0;
    endfunction

endpackage

// File: rtl/trigger_sequencer_if.sv
// Sample and stage-configuration bus feeding the trigger sequencer.
interface trigger_sequencer_if;
    import trigger_sequencer_pkg::*;

    logic       valid;
    sample_t    dataIn;
    logic       cfg_we;
    stage_idx_t cfg_stage;
    sample_t    cfg_mask;
    sample_t    cfg_value;
    sample_t    cfg_rise;
    sample_t    cfg_fall;
    count_t     cfg_count;
    logic       cfg_last;

    modport master (
        output valid, dataIn,
        output cfg_we, cfg_stage, cfg_mask, cfg_value, cfg_rise, cfg_fall, cfg_count, cfg_last
    );

    modport slave (
        input valid, dataIn,
        input cfg_we, cfg_stage, cfg_mask, cfg_value, cfg_rise, cfg_fall, cfg_count, cfg_last
    );

endinterface

// File: rtl/trigger_sequencer_stage_match.sv
// Combinational hit decision for one trigger stage: masked level compare plus
// per-channel edge requirements against the previous valid sample.
module trigger_sequencer_stage_match
    import trigger_sequencer_pkg::*;
(
    input  stage_cfg_t cfg,
    input  sample_t    data,
    input  sample_t    prev,
    input  logic       prev_ok,
    output logic       hit
);

    sample_t rise;
    sample_t fall;
    logic    level_ok;
    logic    unused_cfg;

    // Counting and sequencing fields are consumed by the sequencer, not here.
    assign unused_cfg = ^{cfg.count, cfg.last};

    always_comb begin
        rise     = prev_ok ? (data & ~prev) : '0;
        fall     = prev_ok ? (~data & prev) : '0;
        level_ok = ((data ^ cfg.value) & cfg.mask) == '0;
        hit      = level_ok && edges_ok(cfg.rise, cfg.fall, rise, fall);
    end

endmodule

// File: rtl/trigger_sequencer.sv
// Multi-stage sequential trigger: walks the configured stages in order and
// emits a one-cycle run pulse when the final stage reaches its occurrence count.
module trigger_sequencer
    import trigger_sequencer_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset_n,
    trigger_sequencer_if.slave        bus,
    input  logic                      arm,
    input  logic                      abort,
    output logic                      run,
    output logic                      armed,
    output logic                      triggered,
    output stage_idx_t                stage
);

    localparam logic [STAGE_WIDTH:0] STAGE_LIMIT = (STAGE_WIDTH + 1)'(NUM_STAGES);
    localparam stage_idx_t           LAST_STAGE  = STAGE_WIDTH'(NUM_STAGES - 1);

    stage_cfg_t  cfg_mem [NUM_STAGES];
    stage_cfg_t  cfg_wr;
    stage_cfg_t  cur_cfg;
    trig_state_e state;
    count_t      cnt;
    sample_t     prev;
    logic        prev_ok;
    logic        hit;
    logic        cfg_ok;
    logic        complete;

    assign cfg_wr = '{
        mask:  bus.cfg_mask,
        value: bus.cfg_value,
        rise:  bus.cfg_rise,
        fall:  bus.cfg_fall,
        count: bus.cfg_count,
        last:  bus.cfg_last
    };

    // Configuration is frozen while a sequence is in progress.
    assign cfg_ok   = bus.cfg_we && (state != ARMED) && ({1'b0, bus.cfg_stage} < STAGE_LIMIT);
    assign cur_cfg  = cfg_mem[stage];
    assign complete = cur_cfg.last || (stage == LAST_STAGE);

    trigger_sequencer_stage_match u_match (
        .cfg     (cur_cfg),
        .data    (bus.dataIn),
        .prev    (prev),
        .prev_ok (prev_ok),
        .hit     (hit)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                cfg_mem[i] <= '0;
            end
            state     <= IDLE;
            run       <= 1'b0;
            armed     <= 1'b0;
            triggered <= 1'b0;
            stage     <= '0;
            cnt       <= '0;
            prev      <= '0;
            prev_ok   <= 1'b0;
        end else begin
            run <= 1'b0;

            if (cfg_ok) begin
                cfg_mem[bus.cfg_stage] <= cfg_wr;
            end

            if (bus.valid) begin
                prev <= bus.dataIn;
            end

            // The arm-cycle sample primes prev but never produces an edge.
            if (arm) begin
                prev_ok <= 1'b0;
            end else if (bus.valid) begin
                prev_ok <= 1'b1;
            end

            if (abort) begin
                state <= IDLE;
                armed <= 1'b0;
            end else if (arm) begin
                state     <= ARMED;
                armed     <= 1'b1;
                stage     <= '0;
                cnt       <= '0;
                triggered <= 1'b0;
            end else begin
                case (state)
                    ARMED: begin
                        if (bus.valid && hit) begin
                            if (cnt == cur_cfg.count) begin
                                cnt <= '0;
                                if (complete) begin
                                    state     <= FIRED;
                                    armed     <= 1'b0;
                                    run       <= 1'b1;
                                    triggered <= 1'b1;
                                end else begin
                                    stage <= stage + 1'b1;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
